vnp4_stream_arbiter: RTL
========================

# vnp4_stream_arbiter

Packet-level round-robin arbiter merging `NUM_PORTS` VNP4 AXI-Stream sources onto one VNP4 AXI-Stream sink inside the user plugin. It locks the output to one source from first beat to `last` and never interleaves packets. All beat fields (`data`, `keep`, `last`, every `user_*` field) pass through unmodified. Typical use: merging per-PF/per-CMAC ingress streams ahead of the VNP4 pipeline.

## Interface
Parameters:
- `NUM_PORTS`, 4, number of source streams; legal 2..8.
- `IDX_W`, `$clog2(NUM_PORTS)`, width of grant index (derived, not overridden).

Ports:
- `axis_aclk`  in  1  single clock; everything synchronous to its rising edge.
- `axis_rst`  in  1  asynchronous, active-high reset.
- `s_axis[NUM_PORTS]`  slave modport  `axi_stream_vnp4_if` bundle  source streams; index 0 = port 0.
- `m_axis`  master modport  `axi_stream_vnp4_if` bundle  merged output stream.
- `grant_valid`  out  1  output currently locked to a source.
- `grant_idx`  out  IDX_W  index of locked source; holds last value when `grant_valid`=0.
- `pkt_count`  out  32  packets forwarded (counted on `last` handshake at `m_axis`).

## Operation
- FSM states: IDLE, LOCKED.
- Round-robin pointer `rr_ptr` (IDX_W): search starts at `rr_ptr`, ascending, wraps modulo `NUM_PORTS`; first source with `valid`=1 wins.
- IDLE: all `s_axis[i].ready`=0, `m_axis.valid`=0. If any source valid: register winner into `grant_idx`, `grant_valid`<=1, go LOCKED.
- LOCKED: `m_axis` fields = `s_axis[grant_idx]` fields; `s_axis[grant_idx].ready` = `m_axis.ready`; other readies 0.
- On handshake at `m_axis` with `last`=1: `rr_ptr` <= `grant_idx`+1 (mod `NUM_PORTS`); `pkt_count` += 1. If any source valid that cycle, arbitrate from new pointer (current source searched last) and stay LOCKED with new `grant_idx` (no bubble); else `grant_valid`<=0, go IDLE.
- Single-beat packet (`last` on first beat) handled identically.
- Source dropping `valid` mid-packet: protocol violation; arbiter stays LOCKED, output `valid` follows source, no other source granted.
- `pkt_count` wraps 0xFFFF_FFFF -> 0.
- `NUM_PORTS` not power of two: pointer increments wrap at `NUM_PORTS`-1, never reaching unused codes.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant_valid`=0, `grant_idx`=0, `pkt_count`=0, all `s_axis[i].ready`=0, `m_axis.valid`=0, other `m_axis` fields 0.
- Reset asserted mid-packet: lock dropped immediately (async); partial packet is the source's responsibility.
- From IDLE: source valid in cycle N -> grant registered at edge N+1 -> first beat visible on `m_axis` in cycle N+1 (1-cycle arbitration latency).
- LOCKED passthrough: 0-cycle combinational data and ready path.
- Back-to-back packets from different sources: zero idle cycles between `last` and next first beat.
- Worst-case wait for a continuously valid source: `NUM_PORTS`-1 packets.

## Configuration
- `VNP4_ARB_OUT_REG_EN` defined: `m_axis` driven from a 2-entry skid buffer; LOCKED `s_axis[grant_idx].ready` = buffer not full; no combinational path `m_axis.ready` -> `s_axis[*].ready`; +1 cycle latency source -> sink; full throughput with sink always ready; `pkt_count` and pointer advance on `last` accepted into buffer.
- Undefined: pure combinational passthrough as described above; no buffer storage.

## Structure
- Package `vnp4_arb_pkg`: `vnp4_beat_t` packed struct (data 512, keep 64, last, user_valid, user_size 16, user_src_pf 4, user_src_cmac 10, user_dst_pf 4, user_dst_cmac 10, user_from_direction, user_to_direction); state enum `arb_state_e`; `MAX_PORTS`=8.
- Sub-module `vnp4_skid_buffer` (2-entry, `vnp4_beat_t` payload), instantiated only under `VNP4_ARB_OUT_REG_EN`.

## Test plan
- Single source: port 2 sends 3-beat packet, sink ready -> beats out cycles 1..3 after first valid, `grant_idx`=2, `pkt_count`=1, `rr_ptr`=3.
- Fairness: ports 0..3 all continuously valid with 2-beat packets -> grant order 0,1,2,3,0, no idle cycle between packets, `pkt_count`=5.
- Backpressure: `m_axis.ready` toggles 1010 during 4-beat packet -> no beat lost or duplicated, `user_size`/`user_dst_cmac` match source per beat, other ports' ready stay 0.
- Lock: port 1 mid-packet when port 0 asserts valid -> port 0 waits until port 1 `last` handshake, then granted next cycle.
- Reset mid-packet: assert `axis_rst` on beat 2 of 4 -> `grant_valid`=0, `m_axis.valid`=0, `pkt_count`=0 immediately; after release, port 0 valid -> granted first.
- Wrap: preload 0xFFFF_FFFF packets via forced counter, forward one packet -> `pkt_count`=0; with `VNP4_ARB_OUT_REG_EN`, latency checks above +1 cycle.

Source files
------------

// File: rtl/vnp4_arb_pkg.sv
// Shared types for the VNP4 stream arbiter: beat payload struct and FSM states.
package vnp4_arb_pkg;

    localparam int MAX_PORTS = 8;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic         user_valid;
        logic [15:0]  user_size;
        logic [3:0]   user_src_pf;
        logic [9:0]   user_src_cmac;
        logic [3:0]   user_dst_pf;
        logic [9:0]   user_dst_cmac;
        logic         user_from_direction;
        logic         user_to_direction;
    } vnp4_beat_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

endpackage

// File: rtl/axi_stream_vnp4_if.sv
// VNP4 AXI-Stream bundle: beat fields plus valid/ready handshake.
interface axi_stream_vnp4_if;
    logic         valid;
    logic         ready;
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         user_valid;
    logic [15:0]  user_size;
    logic [3:0]   user_src_pf;
    logic [9:0]   user_src_cmac;
    logic [3:0]   user_dst_pf;
    logic [9:0]   user_dst_cmac;
    logic         user_from_direction;
    logic         user_to_direction;

    modport master (
        output valid, data, keep, last, user_valid, user_size, user_src_pf, user_src_cmac,
               user_dst_pf, user_dst_cmac, user_from_direction, user_to_direction,
        input  ready
    );
    modport slave (
        input  valid, data, keep, last, user_valid, user_size, user_src_pf, user_src_cmac,
               user_dst_pf, user_dst_cmac, user_from_direction, user_to_direction,
        output ready
    );
endinterface

// File: rtl/vnp4_stream_arbiter_skid.sv
// 2-entry skid buffer for vnp4_beat_t; in_ready depends only on occupancy,
// so there is no combinational path from out_ready back to the source.
module vnp4_skid_buffer
    import vnp4_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  vnp4_beat_t in_beat,
    output logic       in_ready,
    output logic       out_valid,
    output vnp4_beat_t out_beat,
    input  logic       out_ready
);
    vnp4_beat_t ent0, ent1;
    logic [1:0] cnt;
    logic       push, pop;

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign out_beat  = ent0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= in_beat;
                    else             ent1 <= in_beat;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                // push with pop only happens at occupancy 1 (full blocks push)
                2'b11: ent0 <= in_beat;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/vnp4_stream_arbiter.sv
// Packet-level round-robin merge of NUM_PORTS VNP4 streams onto one sink.
// Define VNP4_ARB_OUT_REG_EN to register the output through a 2-entry skid buffer.
module vnp4_stream_arbiter
    import vnp4_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic              axis_aclk,
    input  logic              axis_rst,
    axi_stream_vnp4_if.slave  s_axis [NUM_PORTS],
    axi_stream_vnp4_if.master m_axis,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx,
    output logic [31:0]       pkt_count
);
    arb_state_e           state;
    logic [IDX_W-1:0]     rr_ptr, next_ptr, search_ptr, pick_idx;
    logic                 pick_found, locked;
    logic [31:0]          pkt_cnt_q;
    logic [NUM_PORTS-1:0] src_vld, src_rdy;
    vnp4_beat_t           src_beat [NUM_PORTS];
    logic                 sel_vld, side_rdy, acc_last, out_vld, m_rdy;
    vnp4_beat_t           sel_beat, out_beat;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_src
        assign src_vld[i]  = s_axis[i].valid;
        assign src_beat[i] = '{data: s_axis[i].data, keep: s_axis[i].keep, last: s_axis[i].last,
                               user_valid: s_axis[i].user_valid, user_size: s_axis[i].user_size,
                               user_src_pf: s_axis[i].user_src_pf, user_src_cmac: s_axis[i].user_src_cmac,
                               user_dst_pf: s_axis[i].user_dst_pf, user_dst_cmac: s_axis[i].user_dst_cmac,
                               user_from_direction: s_axis[i].user_from_direction,
                               user_to_direction: s_axis[i].user_to_direction};
        assign s_axis[i].ready = src_rdy[i];
    end

    assign locked    = (state == LOCKED);
    assign next_ptr  = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    // Re-arbitration on a last handshake starts after the current owner
    assign search_ptr = locked ? next_ptr : rr_ptr;

    always_comb begin
        int j;
        logic [IDX_W-1:0] jj;
        j          = 0;
        jj         = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            j = int'(search_ptr) + k;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            jj = IDX_W'(j);
            if (src_vld[jj]) begin
                pick_found = 1'b1;
                pick_idx   = jj;
            end
        end
    end

    assign sel_vld  = locked & src_vld[grant_idx];
    assign sel_beat = src_beat[grant_idx];
    assign m_rdy    = m_axis.ready;

`ifdef VNP4_ARB_OUT_REG_EN
    logic buf_rdy;
    vnp4_skid_buffer u_skid (
        .clk       (axis_aclk),
        .rst       (axis_rst),
        .in_valid  (sel_vld),
        .in_beat   (sel_beat),
        .in_ready  (buf_rdy),
        .out_valid (out_vld),
        .out_beat  (out_beat),
        .out_ready (m_rdy)
    );
    assign side_rdy = buf_rdy;
`else
    assign out_vld  = sel_vld;
    assign out_beat = locked ? sel_beat : '0;
    assign side_rdy = m_rdy;
`endif

    assign acc_last = sel_vld & side_rdy & sel_beat.last;

    always_comb begin
        src_rdy = '0;
        if (locked) src_rdy[grant_idx] = side_rdy;
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            pkt_cnt_q   <= '0;
        end else if (state == IDLE) begin
            if (pick_found) begin
                grant_idx   <= pick_idx;
                grant_valid <= 1'b1;
                state       <= LOCKED;
            end
        end else if (acc_last) begin
            rr_ptr    <= next_ptr;
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (pick_found) begin
                grant_idx <= pick_idx;
            end else begin
                grant_valid <= 1'b0;
                state       <= IDLE;
            end
        end
    end

    assign pkt_count                  = pkt_cnt_q;
    assign m_axis.valid               = out_vld;
    assign m_axis.data                = out_beat.data;
    assign m_axis.keep                = out_beat.keep;
    assign m_axis.last                = out_beat.last;
    assign m_axis.user_valid          = out_beat.user_valid;
    assign m_axis.user_size           = out_beat.user_size;
    assign m_axis.user_src_pf         = out_beat.user_src_pf;
    assign m_axis.user_src_cmac       = out_beat.user_src_cmac;
    assign m_axis.user_dst_pf         = out_beat.user_dst_pf;
    assign m_axis.user_dst_cmac       = out_beat.user_dst_cmac;
    assign m_axis.user_from_direction = out_beat.user_from_direction;
    assign m_axis.user_to_direction   = out_beat.user_to_direction;
endmodule
